// File: rtl/pwm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_ctrl_pkg
//  Brief    : Shared types, widths and default loop constants for PWM control
//  Revision : 1.0 - initial release
// ============================================================================
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SOFT_START = 2'd1,
        ST_REGULATE   = 2'd2,
        ST_FAULT      = 2'd3
    } state_t;

    localparam int ADC_W   = 16;
    localparam int DUTY_W  = 8;
    localparam int ERR_W   = 17;
    localparam int INTEG_W = 26;
    localparam int CMD_W   = 27;

    localparam int                DEF_KP_SHIFT  = 4;
    localparam int                DEF_KI_SHIFT  = 8;
    localparam logic [DUTY_W-1:0] DEF_DUTY_MIN  = 8'd8;
    localparam logic [DUTY_W-1:0] DEF_DUTY_MAX  = 8'd230;
    localparam logic [DUTY_W-1:0] DEF_RAMP_STEP = 8'd4;
    localparam logic [ADC_W-1:0]  DEF_ADC_LIMIT = 16'hF000;

endpackage
`default_nettype wire

// File: rtl/sat_add.sv
`default_nettype none
// ============================================================================
//  Module   : sat_add
//  Brief    : Signed adder saturating symmetrically at +/-(2^(W-1)-1)
//  Revision : 1.0 - initial release
// ============================================================================
module sat_add #(
    parameter int W = 26
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum
);

    localparam logic signed [W:0] c_max = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [W:0] c_min = {2'b11, {(W-2){1'b0}}, 1'b1};

    logic signed [W:0] w_wide;

    assign w_wide = {a[W-1], a} + {b[W-1], b};

    always_comb begin
        if (w_wide > c_max)
            sum = c_max[W-1:0];
        else if (w_wide < c_min)
            sum = c_min[W-1:0];
        else
            sum = w_wide[W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/duty_regulator.sv
`default_nettype none
// ============================================================================
//  Module   : duty_regulator
//  Brief    : Per-PWM-period PI duty controller with soft-start and fault latch
//  Revision : 1.0 - initial release
// ============================================================================
module duty_regulator
    import pwm_ctrl_pkg::*;
#(
    parameter int                KP_SHIFT  = DEF_KP_SHIFT,
    parameter int                KI_SHIFT  = DEF_KI_SHIFT,
    parameter logic [DUTY_W-1:0] DUTY_MIN  = DEF_DUTY_MIN,
    parameter logic [DUTY_W-1:0] DUTY_MAX  = DEF_DUTY_MAX,
    parameter logic [DUTY_W-1:0] RAMP_STEP = DEF_RAMP_STEP,
    parameter logic [ADC_W-1:0]  ADC_LIMIT = DEF_ADC_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              Complete,
    input  logic [ADC_W-1:0]  ADC,
    input  logic [ADC_W-1:0]  SETPOINT,
    output logic [DUTY_W-1:0] DUTY_CYCLE,
    output logic              update,
    output logic              Fault,
    output logic [1:0]        state
);

    localparam logic signed [CMD_W-1:0]   c_cmd_max   = {{(CMD_W-DUTY_W){1'b0}}, DUTY_MAX};
    localparam logic signed [CMD_W-1:0]   c_cmd_min   = {{(CMD_W-DUTY_W){1'b0}}, DUTY_MIN};
    localparam logic signed [INTEG_W-1:0] c_integ_pre = {{(INTEG_W-DUTY_W){1'b0}}, DUTY_MIN} << KI_SHIFT;

    state_t                    r_state, w_state_nxt;
    logic [DUTY_W-1:0]         r_duty, w_duty_nxt;
    logic signed [INTEG_W-1:0] r_integ, w_integ_nxt;
    logic                      r_update, w_update_nxt;

    logic                      r_v0, r_v1, r_v2;
    logic [ADC_W-1:0]          r_adc, r_sp;
    logic signed [ERR_W-1:0]   r_err;
    logic [DUTY_W-1:0]         r_duty_cmd;
    logic signed [INTEG_W-1:0] r_integ_upd;

    logic                      w_running, w_trip, w_live, w_busy, w_capture;
    logic signed [ERR_W-1:0]   w_p17;
    logic signed [INTEG_W-1:0] w_i26, w_err_ext, w_integ_sum;
    logic signed [CMD_W-1:0]   w_p, w_i, w_cmd;
    logic                      w_err_pos, w_err_neg, w_hold;
    logic [DUTY_W-1:0]         w_duty_cmd, w_ss_duty;
    logic [DUTY_W:0]           w_ramp;

    assign w_running = (r_state == ST_SOFT_START) || (r_state == ST_REGULATE);
    assign w_trip    = w_running && r_v0 && (r_adc > ADC_LIMIT);
    assign w_live    = w_running && enable && !w_trip;
    assign w_busy    = r_v0 || r_v1 || r_v2;
    assign w_capture = w_live && Complete && !w_busy;

    // Stage 2: P/I terms, clamped command and anti-windup decision
    assign w_p17     = r_err >>> KP_SHIFT;
    assign w_i26     = r_integ >>> KI_SHIFT;
    assign w_p       = {{(CMD_W-ERR_W){w_p17[ERR_W-1]}}, w_p17};
    assign w_i       = {{(CMD_W-INTEG_W){w_i26[INTEG_W-1]}}, w_i26};
    assign w_err_ext = {{(INTEG_W-ERR_W){r_err[ERR_W-1]}}, r_err};

    sat_add #(.W(CMD_W)) u_cmd_add (
        .a   (w_p),
        .b   (w_i),
        .sum (w_cmd)
    );

    sat_add #(.W(INTEG_W)) u_integ_add (
        .a   (r_integ),
        .b   (w_err_ext),
        .sum (w_integ_sum)
    );

    assign w_err_neg = r_err[ERR_W-1];
    assign w_err_pos = !r_err[ERR_W-1] && (r_err != '0);
    assign w_hold    = ((w_cmd > c_cmd_max) && w_err_pos) ||
                       ((w_cmd < c_cmd_min) && w_err_neg);

    always_comb begin
        if (w_cmd > c_cmd_max)
            w_duty_cmd = DUTY_MAX;
        else if (w_cmd < c_cmd_min)
            w_duty_cmd = DUTY_MIN;
        else
            w_duty_cmd = w_cmd[DUTY_W-1:0];
    end

    assign w_ramp    = {1'b0, r_duty} + {1'b0, RAMP_STEP};
    assign w_ss_duty = (w_ramp > {1'b0, r_duty_cmd}) ? r_duty_cmd : w_ramp[DUTY_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v0        <= 1'b0;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_adc       <= '0;
            r_sp        <= '0;
            r_err       <= '0;
            r_duty_cmd  <= '0;
            r_integ_upd <= '0;
        end else begin
            r_v0 <= w_capture;
            r_v1 <= r_v0 && w_live;
            r_v2 <= r_v1 && w_live;
            if (w_capture) begin
                r_adc <= ADC;
                r_sp  <= SETPOINT;
            end
            if (r_v0)
                r_err <= $signed({1'b0, r_sp}) - $signed({1'b0, r_adc});
            if (r_v1) begin
                r_duty_cmd  <= w_duty_cmd;
                r_integ_upd <= w_hold ? r_integ : w_integ_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_duty   <= '0;
            r_integ  <= '0;
            r_update <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_duty   <= w_duty_nxt;
            r_integ  <= w_integ_nxt;
            r_update <= w_update_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_duty_nxt   = r_duty;
        w_integ_nxt  = r_integ;
        w_update_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_duty_nxt  = '0;
                w_integ_nxt = '0;
                if (enable) begin
                    w_state_nxt = ST_SOFT_START;
                    w_duty_nxt  = DUTY_MIN;
                    w_integ_nxt = c_integ_pre;
                end
            end
            ST_SOFT_START, ST_REGULATE: begin
                // Fault outranks disable so an over-limit sample always latches
                if (w_trip) begin
                    w_state_nxt = ST_FAULT;
                    w_duty_nxt  = '0;
                    w_integ_nxt = '0;
                end else if (!enable) begin
                    w_state_nxt = ST_IDLE;
                    w_duty_nxt  = '0;
                    w_integ_nxt = '0;
                end else if (r_v2) begin
                    w_update_nxt = 1'b1;
                    if (r_state == ST_SOFT_START) begin
                        w_duty_nxt = w_ss_duty;
                        if (w_ss_duty == r_duty_cmd)
                            w_state_nxt = ST_REGULATE;
                    end else begin
                        w_duty_nxt  = r_duty_cmd;
                        w_integ_nxt = r_integ_upd;
                    end
                end
            end
            ST_FAULT: begin
                w_duty_nxt  = '0;
                w_integ_nxt = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign DUTY_CYCLE = r_duty;
    assign update     = r_update;
    assign Fault      = (r_state == ST_FAULT);
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_duty_regulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_duty_regulator
//  Brief    : Directed self-checking bench for duty_regulator
//  Revision : 1.0 - initial release
// ============================================================================
module tb_duty_regulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        Complete;
    logic [15:0] ADC;
    logic [15:0] SETPOINT;
    logic [7:0]  DUTY_CYCLE;
    logic        update;
    logic        Fault;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    duty_regulator dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .Complete   (Complete),
        .ADC        (ADC),
        .SETPOINT   (SETPOINT),
        .DUTY_CYCLE (DUTY_CYCLE),
        .update     (update),
        .Fault      (Fault),
        .state      (state)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One period of len clocks; ok means exactly one pulse, 3 edges after capture
    task automatic do_period(input int len, output logic [7:0] d, output bit ok);
        int cnt;
        cnt = 0;
        ok  = 1'b1;
        d   = 'x;
        Complete = 1'b1;
        tick();
        Complete = 1'b0;
        for (int c = 1; c < len; c++) begin
            tick();
            if (update) begin
                cnt++;
                if (c != 3) ok = 1'b0;
                else        d  = DUTY_CYCLE;
            end
        end
        if (cnt != 1) ok = 1'b0;
    endtask

    task automatic count_pulses(input int n, output int cnt, output logic [7:0] last);
        cnt  = 0;
        last = 'x;
        for (int c = 0; c < n; c++) begin
            tick();
            if (update) begin
                cnt++;
                last = DUTY_CYCLE;
            end
        end
    endtask

    initial begin
        logic [7:0] d;
        bit         ok;
        int         cnt;
        int         bad_periods;
        logic [7:0] exp_d;

        rst = 1'b1; enable = 1'b0; Complete = 1'b0; ADC = '0; SETPOINT = '0;
        tick(3);
        check_val("rst_duty",   DUTY_CYCLE, 0);
        check_val("rst_update", update, 0);
        check_val("rst_fault",  Fault, 0);
        check_val("rst_state",  state, 0);
        rst = 1'b0;
        tick(2);
        check_val("idle_duty", DUTY_CYCLE, 0);

        // Soft-start ramp towards a saturated command
        SETPOINT = 16'h4000; ADC = 16'h0000; enable = 1'b1;
        tick();
        check_val("ss_entry_state", state, 1);
        check_val("ss_entry_duty",  DUTY_CYCLE, 8);
        for (int k = 1; k <= 56; k++) begin
            do_period(20, d, ok);
            exp_d = (k < 56) ? 8'(8 + 4 * k) : 8'd230;
            check_val($sformatf("ss_duty_%0d", k), d, exp_d);
            check_val($sformatf("ss_timing_%0d", k), ok, 1);
            check_val($sformatf("ss_state_%0d", k), state, (k < 56) ? 1 : 2);
        end

        // Long positive error at the upper clamp, then a hard reversal
        bad_periods = 0;
        for (int k = 0; k < 1000; k++) begin
            do_period(5, d, ok);
            if (!ok || d !== 8'd230) bad_periods++;
        end
        check_val("aw_sat_periods", bad_periods, 0);
        ADC = 16'h8000;
        do_period(5, d, ok);
        check_val("aw_first_duty", d, 8);
        check_val("aw_first_ok",   ok, 1);
        do_period(5, d, ok);
        check_val("aw_second_duty", d, 8);

        // Reset asserted while a sample is in flight
        Complete = 1'b1; tick(); Complete = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check_val("midrst_duty",   DUTY_CYCLE, 0);
        check_val("midrst_update", update, 0);
        check_val("midrst_fault",  Fault, 0);
        check_val("midrst_state",  state, 0);
        rst = 1'b0;
        count_pulses(6, cnt, d);
        check_val("midrst_pulses", cnt, 0);

        // Steady state at zero error, then a small positive error
        SETPOINT = 16'h1000; ADC = 16'h1000;
        do_period(5, d, ok);
        check_val("st_first_duty", d, 8);
        check_val("st_state",      state, 2);
        bad_periods = 0;
        for (int k = 0; k < 100; k++) begin
            do_period(5, d, ok);
            if (!ok || d !== 8'd8) bad_periods++;
        end
        check_val("st_constant", bad_periods, 0);
        ADC = 16'h0FF0;
        do_period(5, d, ok);
        check_val("st_small_err_duty", d, 9);

        // Disable at t+2 drops the pending result
        Complete = 1'b1; tick(); Complete = 1'b0;
        tick();
        enable = 1'b0;
        tick();
        check_val("dis_state",  state, 0);
        check_val("dis_duty",   DUTY_CYCLE, 0);
        check_val("dis_update", update, 0);
        count_pulses(4, cnt, d);
        check_val("dis_pulses", cnt, 0);

        // Disable and Complete in the same cycle: no capture
        enable = 1'b1;
        tick();
        check_val("reen_duty", DUTY_CYCLE, 8);
        enable = 1'b0; Complete = 1'b1;
        tick();
        Complete = 1'b0; enable = 1'b1;
        check_val("same_cyc_state", state, 0);
        count_pulses(6, cnt, d);
        check_val("same_cyc_pulses", cnt, 0);

        // Second Complete one cycle later is ignored
        SETPOINT = 16'h4000; ADC = 16'h0000;
        Complete = 1'b1; tick(); tick(); Complete = 1'b0;
        count_pulses(6, cnt, d);
        check_val("ign_pulses", cnt, 1);
        check_val("ign_duty",   d, 12);

        // Sample equal to the limit does not trip
        ADC = 16'hF000;
        do_period(5, d, ok);
        check_val("lim_eq_duty",  d, 8);
        check_val("lim_eq_fault", Fault, 0);
        check_val("lim_eq_state", state, 2);

        // Over-limit sample latches the fault
        ADC = 16'hF001;
        Complete = 1'b1; tick(); Complete = 1'b0;
        tick();
        check_val("flt_fault", Fault, 1);
        check_val("flt_duty",  DUTY_CYCLE, 0);
        check_val("flt_state", state, 3);
        count_pulses(5, cnt, d);
        check_val("flt_pulses", cnt, 0);
        ADC = 16'h0000; enable = 1'b0;
        tick(2);
        enable = 1'b1;
        Complete = 1'b1; tick(); Complete = 1'b0;
        count_pulses(5, cnt, d);
        check_val("flt_hold_pulses", cnt, 0);
        check_val("flt_hold_fault",  Fault, 1);
        check_val("flt_hold_state",  state, 3);
        check_val("flt_hold_duty",   DUTY_CYCLE, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("flt_clr_fault", Fault, 0);
        check_val("flt_clr_state", state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
